// File: rtl/sram_pkg.sv
// Constants and types shared between the SRAM device model and the
// memory-stage controller.
package sram_pkg;

    localparam int SRAM_DATA_W  = 16;
    localparam int SRAM_ADDR_W  = 18;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 8;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic [SRAM_DATA_W-1:0] data;
        logic                   valid;
    } rd_stage_t;

    // Forces a latency into the supported range so a bad override still
    // builds a working (if mis-timed) pipeline instead of a zero-depth one.
    function automatic int clamp_lat(input int lat);
        if (lat < READ_LAT_MIN) return READ_LAT_MIN;
        if (lat > READ_LAT_MAX) return READ_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return shift pipeline. Stage 0 takes each new launch and the last
// stage feeds the DQ driver. Only the valid bits are reset or flushed; the
// data bits simply follow the pushes.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      flush,
    input  rd_stage_t push_stage,
    output rd_stage_t last_stage
);

    logic [DEPTH-1:0]       valid_q;
    logic [SRAM_DATA_W-1:0] data_q [DEPTH];

    // Valid bits: async clear on reset, synchronous clear on flush, shift on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (push) begin
            valid_q[0] <= push_stage.valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data bits: shift alongside the valid bits; no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_q[0] <= push_stage.data;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign last_stage.data  = data_q[DEPTH-1];
    assign last_stage.valid = valid_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Device-side model of the external 16-bit SRAM. Captures writes, returns
// read data after READ_LAT cycles, owns the device side of DQ, and keeps
// access counters plus sticky error flags.
// The array has no reset: FPGA configuration leaves it all-zero and a
// reset of the logic must not disturb stored contents.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              oob_err,
    output logic              bus_err
);

    localparam int LAT = clamp_lat(READ_LAT);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic [MEM_AW-1:0] mem_addr;
    logic              addr_oob;
    logic              is_write;
    rd_stage_t         push_stage;
    rd_stage_t         last_stage;

    assign mem_addr   = SRAM_ADDR[MEM_AW-1:0];
    assign addr_oob   = |SRAM_ADDR[ADDR_W-1:MEM_AW];
    assign is_write   = ~SRAM_WE_N;

    // Data is taken from the array at launch time, so a later write to the
    // same word cannot alter a read already in flight (it flushes it anyway).
    assign push_stage.data  = mem[mem_addr];
    assign push_stage.valid = 1'b1;

    sram_rd_pipe #(
        .DEPTH (LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (SRAM_WE_N),
        .flush      (is_write),
        .push_stage (push_stage),
        .last_stage (last_stage)
    );

    // WE_N gates the driver combinationally so the device lets go of DQ in
    // the same cycle the controller turns the bus around.
    assign SRAM_DQ = (SRAM_WE_N && last_stage.valid) ? last_stage.data : 'z;

    // Array write port.
    always_ff @(posedge clk) begin
        if (is_write) begin
            mem[mem_addr] <= SRAM_DQ;
        end
    end

    // Access counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
            oob_err  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (SRAM_WE_N) begin
                rd_count <= rd_count + 32'd1;
            end else begin
                wr_count <= wr_count + 32'd1;
            end
            if (addr_oob) begin
                oob_err <= 1'b1;
            end
            if (is_write && last_stage.valid) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (READ_LAT 1, 2, 8) share the
// controller stimulus; a per-instance queue holds the expected DQ returns.
module tb_sram_responder;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr = '0;
    logic        we_n = 1'b1;
    logic        drv_en = 1'b0;
    logic [15:0] drv_data = '0;

    always #5 clk = ~clk;

    wire [15:0] dq1, dq2, dq8;
    assign dq1 = drv_en ? drv_data : 'z;
    assign dq2 = drv_en ? drv_data : 'z;
    assign dq8 = drv_en ? drv_data : 'z;

    wire [15:0] dq_obs [3];
    assign dq_obs[0] = dq1;
    assign dq_obs[1] = dq2;
    assign dq_obs[2] = dq8;

    wire [31:0] rd_c [3];
    wire [31:0] wr_c [3];
    wire        oob  [3];
    wire        bus  [3];

    sram_responder #(.READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
        .rd_count(rd_c[0]), .wr_count(wr_c[0]), .oob_err(oob[0]), .bus_err(bus[0]));
    sram_responder #(.READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
        .rd_count(rd_c[1]), .wr_count(wr_c[1]), .oob_err(oob[1]), .bus_err(bus[1]));
    sram_responder #(.READ_LAT(8)) u_l8 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq8), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
        .rd_count(rd_c[2]), .wr_count(wr_c[2]), .oob_err(oob[2]), .bus_err(bus[2]));

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    int          lats [3] = '{1, 2, 8};
    exp_t        sb [3][$];
    logic [15:0] mm [int];
    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    int          rd_exp   = 0;
    int          wr_exp   = 0;
    logic        oob_exp  = 1'b0;
    logic        bus_exp [3] = '{1'b0, 1'b0, 1'b0};
    logic        drv_exp [3] = '{1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Released bus reads as Z in 4-state simulators and as 0 in 2-state
    // ones; test data is always nonzero so a stale drive is still visible.
    task automatic chk_rel(input string tag, input logic [15:0] obs);
        checks++;
        assert ($isunknown(obs) || obs == 16'h0000) else begin
            failures++;
            $error("FAIL %s observed=%h expected=released", tag, obs);
        end
    endtask

    task automatic check_status(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_rd_l%0d", tag, lats[k]), rd_c[k], rd_exp);
            chk($sformatf("%s_wr_l%0d", tag, lats[k]), wr_c[k], wr_exp);
            chk($sformatf("%s_oob_l%0d", tag, lats[k]), {31'd0, oob[k]}, {31'd0, oob_exp});
            chk($sformatf("%s_bus_l%0d", tag, lats[k]), {31'd0, bus[k]}, {31'd0, bus_exp[k]});
        end
    endtask

    // One controller cycle, entered and left at a falling edge.
    task automatic step(input logic w_n, input logic [17:0] a, input logic [15:0] wd,
                        input string tag);
        exp_t e;
        we_n     = w_n;
        addr     = a;
        drv_en   = ~w_n;
        drv_data = wd;
        #1;
        if (!w_n) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s_wdrive_l%0d", tag, lats[k]), {16'd0, dq_obs[k]}, {16'd0, wd});
        end
        @(posedge clk);
        edge_n++;
        if (a[17:16] != 2'b00) oob_exp = 1'b1;
        if (!w_n) begin
            mm[int'(a[15:0])] = wd;
            wr_exp++;
            for (int k = 0; k < 3; k++) begin
                if (drv_exp[k]) bus_exp[k] = 1'b1;
                sb[k].delete();
                drv_exp[k] = 1'b0;
            end
        end else begin
            rd_exp++;
            for (int k = 0; k < 3; k++)
                sb[k].push_back('{due: edge_n + lats[k] - 1, data: mm[int'(a[15:0])]});
        end
        @(negedge clk);
        if (w_n) begin
            for (int k = 0; k < 3; k++) begin
                if (sb[k].size() > 0 && sb[k][0].due == edge_n) begin
                    e = sb[k].pop_front();
                    chk($sformatf("%s_dq_l%0d", tag, lats[k]), {16'd0, dq_obs[k]}, {16'd0, e.data});
                    drv_exp[k] = 1'b1;
                end else begin
                    chk_rel($sformatf("%s_dqz_l%0d", tag, lats[k]), dq_obs[k]);
                    drv_exp[k] = 1'b0;
                end
            end
        end
        check_status(tag);
    endtask

    task automatic reads(input logic [17:0] a, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, a, 16'h0000, tag);
    endtask

    initial begin
        #2;
        for (int k = 0; k < 3; k++) chk_rel($sformatf("rst_dqz_l%0d", lats[k]), dq_obs[k]);
        check_status("rst");
        @(negedge clk);
        rst = 1'b0;

        // Write then read same address.
        step(1'b0, 18'h00012, 16'hBEEF, "wr_beef");
        reads(18'h00012, 10, "rd_beef");

        // Preload for turnaround and flush.
        step(1'b0, 18'h00005, 16'h5A5A, "pre5");
        step(1'b0, 18'h00001, 16'h1111, "pre1");
        step(1'b0, 18'h00002, 16'h2222, "pre2");

        // Turnaround: write on the cycle the LAT=2 data appears.
        reads(18'h00005, 2, "ta_rd");
        step(1'b0, 18'h00005, 16'hC0DE, "ta_wr");
        reads(18'h00005, 9, "ta_chk");

        // Flush: two reads in flight, then a write.
        step(1'b1, 18'h00001, 16'h0000, "fl_rd1");
        step(1'b1, 18'h00002, 16'h0000, "fl_rd2");
        step(1'b0, 18'h00003, 16'h1234, "fl_wr");
        reads(18'h00003, 9, "fl_chk");

        // Alias / out-of-range write.
        step(1'b0, 18'h10007, 16'hA5A5, "oob_wr");
        reads(18'h00007, 9, "alias_rd");

        // Async reset in the middle of reads.
        reads(18'h00012, 3, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            drv_exp[k] = 1'b0;
            bus_exp[k] = 1'b0;
            chk_rel($sformatf("midrst_dqz_l%0d", lats[k]), dq_obs[k]);
        end
        rd_exp  = 0;
        wr_exp  = 0;
        oob_exp = 1'b0;
        check_status("midrst");
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_rel($sformatf("inrst_dqz_l%0d", lats[k]), dq_obs[k]);
        rst = 1'b0;
        reads(18'h00012, 9, "post_rst");

        // Out-of-range read sets oob and aliases.
        reads(18'h30012, 3, "oob_rd");
        reads(18'h00003, 9, "final_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable device-side model of the external 16-bit SRAM that the processor's memory stage drives via SRAM_ADDR / SRAM_DQ / SRAM_WE_N.
- Answers the controller: captures writes, returns read data after a programmable latency, and owns the device side of the shared DQ bus.
- Used in simulation benches and FPGA loopback builds in place of the physical chip.
- Exposes access counters and sticky error flags for verification.

Parameters:
- DATA_W, 16, width of SRAM_DQ and of each stored word.
- ADDR_W, 18, width of SRAM_ADDR.
- MEM_AW, 16, implemented array address bits (2^MEM_AW words); addresses alias modulo 2^MEM_AW.
- READ_LAT, 2, cycles from read-address sample to data driven on DQ; legal range 1..8.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SRAM_DQ  inout  DATA_W  bidirectional data; device drives only on read.
- SRAM_ADDR  input  ADDR_W  word address from controller.
- SRAM_WE_N  input  1  active-low write enable; high = read cycle.
- rd_count  output  32  number of read launches since reset.
- wr_count  output  32  number of words written since reset.
- oob_err  output  1  sticky; an access used nonzero address bits at or above MEM_AW.
- bus_err  output  1  sticky; WE_N fell while read data was being driven.

Behaviour:
- Reset (async, active-high):
  - Read pipeline valid bits, rd_count, wr_count, oob_err and bus_err clear to 0 immediately.
  - DQ releases to Z in the same instant.
  - Array contents are preserved; they start at all-zero after configuration.
- Write, at a rising edge with WE_N=0:
  - mem[SRAM_ADDR[MEM_AW-1:0]] <= SRAM_DQ.
  - wr_count increments by 1.
  - All read-pipeline valid bits clear (flush), so no stale data is ever driven after a write.
- Read launch, at a rising edge with WE_N=1:
  - Push {mem[addr], valid=1} into stage 0 of a READ_LAT-deep shift pipeline; older entries shift by one.
  - rd_count increments by 1.
  - Every cycle with WE_N=1 is a read launch; the controller holds the address for repeated cycles.
- Data timing:
  - A read launched at edge N appears on DQ after edge N+READ_LAT-1.
  - It is therefore sampleable by the controller at edge N+READ_LAT.
  - The data value is read from the array at launch time.
- DQ drive:
  - DQ = last_stage.data when (SRAM_WE_N==1 && last_stage.valid), else Z.
  - The WE_N gating is combinational, so the device releases DQ in the same cycle the controller lowers WE_N. There is no contention cycle from the device side.
- bus_err: set at a rising edge where WE_N=0 and last_stage.valid=1 (the controller turned the bus around while a read was still returning); it stays set until reset.
- oob_err: set at any access edge (read or write) where SRAM_ADDR[ADDR_W-1:MEM_AW] != 0; the access still proceeds on the aliased address. Sticky.
- Counters: wrap modulo 2^32, no saturation.
- Write-then-read, same address: the write at edge N followed by a read launch at edge N+1 returns the new data. Nothing is in flight across the write because of the flush.
- Read-then-write: in-flight reads are discarded; DQ stays Z through the write and for READ_LAT-1 cycles after the first subsequent read launch.
- Reset mid-read: pending data is lost; the first DQ drive after reset requires a fresh launch plus the full READ_LAT.

Decomposition:
- Shared package sram_pkg:
  - SRAM_DATA_W=16 and SRAM_ADDR_W=18 constants, shared with the memory-stage controller.
  - READ_LAT bounds.
  - Typedef rd_stage_t {data[DATA_W-1:0], valid}.
- One sub-module, sram_rd_pipe: the READ_LAT-deep shift pipeline of rd_stage_t with push and flush inputs, and async reset of the valid bits.
- The array, the tristate buffer, the counters and the flags stay in the top module.

Test Plan:
- Write then read: write 0xBEEF to address 0x00012 (WE_N=0, one cycle), then WE_N=1 holding address 0x00012 → DQ=0xBEEF from edge READ_LAT onward; wr_count=1, rd_count increments each read cycle.
- Latency sweep: READ_LAT=1, 2 and 8, read a preloaded address → DQ is Z before the expected edge and correct at exactly edge N+READ_LAT.
- Turnaround: start a read of 0x0005, lower WE_N on the cycle data appears → DQ released in the same cycle; bus_err=1 after the edge; the write data lands in the array.
- Flush: launch reads of 0x0001 and 0x0002, write 0x1234 to 0x0003 before they return → neither stale read is ever driven; reading 0x0003 afterwards returns 0x1234.
- Alias/oob: write 0xA5A5 to 0x10007 (MEM_AW=16) → oob_err=1; a read of 0x00007 returns 0xA5A5.
- Async reset mid-read: assert rst between launch and return → DQ=Z, counters=0, flags=0 immediately; contents written before reset are still readable after rst deasserts.
